// File: rtl/suma_pkg.sv
// suma_pkg
// Shared definitions for the sequential offset generator (suma_secuencial)
// and its accumulate step (suma_paso).
//   estado_t : FSM states REPOSO / EMITE / FIN
//   INDICE_W : width of the beat index output (indice)

package suma_pkg;

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        EMITE  = 2'd1,
        FIN    = 2'd2
    } estado_t;

    localparam int INDICE_W = 8;

endpackage

// File: rtl/suma_paso.sv
// suma_paso
// One accumulate step: resultado = operando + PASO, computed on ANCHO+1 bits
// so the carry out tells whether the exact sum left the ANCHO-bit range.
// Optional build macro: SUMA_SATURA_EN (defined -> clamp to 2^ANCHO-1,
// undefined -> wrap modulo 2^ANCHO).
// Ports:
//   operando  in  ANCHO  previous position (or base on the first beat)
//   resultado out ANCHO  next position after wrap/saturate selection
//   desborde  out 1      exact sum exceeded 2^ANCHO-1 on this step

module suma_paso
    import suma_pkg::*;
#(
    parameter int ANCHO = 10,
    parameter int PASO  = 1
) (
    input  logic [ANCHO-1:0] operando,
    output logic [ANCHO-1:0] resultado,
    output logic             desborde
);

    localparam logic [ANCHO:0]   PASO_EXT = (ANCHO+1)'(PASO);
    localparam logic [ANCHO-1:0] MAXIMO   = '1;

    logic [ANCHO:0] suma;

    // The extra top bit is the carry; it flags the step that crosses the
    // top of the range. Once saturated, the operand stays at MAXIMO and any
    // PASO >= 1 carries again, so the output keeps clamping.
    assign suma     = {1'b0, operando} + PASO_EXT;
    assign desborde = suma[ANCHO];

`ifdef SUMA_SATURA_EN
    assign resultado = suma[ANCHO] ? MAXIMO : suma[ANCHO-1:0];
`else
    assign resultado = suma[ANCHO-1:0];
`endif

endmodule

// File: rtl/suma_secuencial.sv
// suma_secuencial
// On a start request, emits CUENTA positions base+PASO, base+2*PASO, ...
// over a valid/ready handshake, one beat per cycle at full throughput.
// The product k*PASO is never formed: each beat is the previous one plus
// PASO, produced by a single suma_paso instance.
// Optional build macro: SUMA_SATURA_EN (saturating instead of wrapping sums).
// Ports:
//   clk        in  1        clock, rising edge
//   reset      in  1        asynchronous, active-high reset
//   Posicion   in  ANCHO    base position, sampled on an accepted start
//   inicio     in  1        start request (ignored unless idle)
//   ocupado    out 1        sequence in progress (EMITE or FIN)
//   pos        out ANCHO    current offset position
//   pos_valido out 1        pos holds a valid beat
//   pos_listo  in  1        downstream ready
//   indice     out 8        index k (1..CUENTA) of the beat on pos
//   fin        out 1        one-cycle pulse after the last beat transfers
//   desborde   out 1        sticky overflow flag for the current sequence

module suma_secuencial
    import suma_pkg::*;
#(
    parameter int ANCHO  = 10,
    parameter int CUENTA = 12,
    parameter int PASO   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ANCHO-1:0]    Posicion,
    input  logic                inicio,
    output logic                ocupado,
    output logic [ANCHO-1:0]    pos,
    output logic                pos_valido,
    input  logic                pos_listo,
    output logic [INDICE_W-1:0] indice,
    output logic                fin,
    output logic                desborde
);

    localparam logic [INDICE_W-1:0] CUENTA_K = INDICE_W'(CUENTA);

    estado_t             estado;
    estado_t             estado_sig;
    logic [ANCHO-1:0]    pos_r;
    logic [INDICE_W-1:0] k_r;
    logic                desb_r;

    logic [ANCHO-1:0]    operando;
    logic [ANCHO-1:0]    siguiente;
    logic                paso_desb;
    logic                arranque;
    logic                transfiere;
    logic                ultimo;

    assign arranque   = (estado == REPOSO) && inicio;
    assign transfiere = (estado == EMITE) && pos_listo;
    assign ultimo     = (k_r == CUENTA_K);

    // While idle the step adds PASO to the incoming base, so the first beat
    // is ready the cycle after the start; afterwards it advances the beat
    // currently on pos. The base itself never needs its own register.
    assign operando = (estado == REPOSO) ? Posicion : pos_r;

    suma_paso #(
        .ANCHO (ANCHO),
        .PASO  (PASO)
    ) u_paso (
        .operando  (operando),
        .resultado (siguiente),
        .desborde  (paso_desb)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado <= REPOSO;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next-state logic: start only from idle, leave EMITE on the transfer of
    // the last beat, and spend exactly one cycle in FIN.
    always_comb begin
        estado_sig = estado;
        case (estado)
            REPOSO: begin
                if (inicio) begin
                    estado_sig = EMITE;
                end
            end
            EMITE: begin
                if (pos_listo && ultimo) begin
                    estado_sig = FIN;
                end
            end
            FIN: begin
                estado_sig = REPOSO;
            end
            default: begin
                estado_sig = REPOSO;
            end
        endcase
    end

    // Beat registers. Nothing changes while pos_listo is low, which keeps
    // the presented beat stable. The overflow flag restarts from the first
    // beat's own carry on a start and then accumulates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_r  <= '0;
            k_r    <= '0;
            desb_r <= 1'b0;
        end else if (arranque) begin
            pos_r  <= siguiente;
            k_r    <= INDICE_W'(1);
            desb_r <= paso_desb;
        end else if (transfiere && !ultimo) begin
            pos_r  <= siguiente;
            k_r    <= k_r + INDICE_W'(1);
            desb_r <= desb_r | paso_desb;
        end
    end

    assign pos        = pos_r;
    assign indice     = k_r;
    assign desborde   = desb_r;
    assign pos_valido = (estado == EMITE);
    assign fin        = (estado == FIN);
    assign ocupado    = (estado != REPOSO);

endmodule

// File: tb/tb_suma_secuencial.sv
// tb_suma_secuencial
// Self-checking bench for suma_secuencial. Two instances: one with default
// parameters and one with PASO=4, CUENTA=3. Expected beats come from an
// exact-arithmetic model and are queued when a sequence is started; a
// monitor per instance pops and compares every transferred beat.
// Honours SUMA_SATURA_EN in its model.

module tb_suma_secuencial;

    import suma_pkg::*;

    localparam int ANCHO  = 10;
    localparam int MAXIMO = (1 << ANCHO) - 1;

    typedef struct {
        int pos;
        int indice;
        bit desb;
    } beat_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;

    logic [ANCHO-1:0]    Posicion = '0;
    logic                inicio = 1'b0;
    logic                ocupado;
    logic [ANCHO-1:0]    pos;
    logic                pos_valido;
    logic                pos_listo = 1'b1;
    logic [INDICE_W-1:0] indice;
    logic                fin;
    logic                desborde;

    logic [ANCHO-1:0]    Posicion2 = '0;
    logic                inicio2 = 1'b0;
    logic                ocupado2;
    logic [ANCHO-1:0]    pos2;
    logic                pos_valido2;
    logic                pos_listo2 = 1'b1;
    logic [INDICE_W-1:0] indice2;
    logic                fin2;
    logic                desborde2;

    int checks = 0;
    int errors = 0;

    beat_t q1[$];
    beat_t q2[$];

    always #5 clk = ~clk;

    suma_secuencial #(.ANCHO(ANCHO), .CUENTA(12), .PASO(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .Posicion   (Posicion),
        .inicio     (inicio),
        .ocupado    (ocupado),
        .pos        (pos),
        .pos_valido (pos_valido),
        .pos_listo  (pos_listo),
        .indice     (indice),
        .fin        (fin),
        .desborde   (desborde)
    );

    suma_secuencial #(.ANCHO(ANCHO), .CUENTA(3), .PASO(4)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .Posicion   (Posicion2),
        .inicio     (inicio2),
        .ocupado    (ocupado2),
        .pos        (pos2),
        .pos_valido (pos_valido2),
        .pos_listo  (pos_listo2),
        .indice     (indice2),
        .fin        (fin2),
        .desborde   (desborde2)
    );

    // Exact model: base + k*paso, then wrap or clamp.
    function automatic beat_t modelo(input int base, input int k, input int paso);
        beat_t b;
        int    exacto;
        exacto   = base + k * paso;
        b.indice = k;
        b.desb   = (exacto > MAXIMO);
`ifdef SUMA_SATURA_EN
        b.pos = (exacto > MAXIMO) ? MAXIMO : exacto;
`else
        b.pos = exacto % (MAXIMO + 1);
`endif
        return b;
    endfunction

    task automatic encolar(input int cual, input int base, input int n, input int paso);
        for (int k = 1; k <= n; k++) begin
            if (cual == 1) q1.push_back(modelo(base, k, paso));
            else           q2.push_back(modelo(base, k, paso));
        end
    endtask

    // Waits (bounded) until the chosen scoreboard queue is drained; returns
    // at the rising edge following the last popped beat.
    task automatic esperar_vacio(input int cual, input int limite, output int ciclos, output bit ok);
        ok     = 1'b0;
        ciclos = 0;
        for (int i = 0; i < limite; i++) begin
            @(posedge clk);
            ciclos++;
            if ((cual == 1 && q1.size() == 0) || (cual == 2 && q2.size() == 0)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Scoreboard monitor for the default instance.
    always @(negedge clk) begin
        beat_t e;
        if (!reset && pos_valido && pos_listo) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("[TB] FAIL beat_extra: pos=%0d indice=%0d with no beat expected", pos, indice);
            end else begin
                e = q1.pop_front();
                if (pos !== e.pos || indice !== e.indice || desborde !== e.desb) begin
                    errors++;
                    $display("[TB] FAIL beat: got pos=%0d indice=%0d desborde=%0b, need pos=%0d indice=%0d desborde=%0b",
                             pos, indice, desborde, e.pos, e.indice, e.desb);
                end
            end
        end
    end

    // Scoreboard monitor for the PASO=4 instance.
    always @(negedge clk) begin
        beat_t e;
        if (!reset && pos_valido2 && pos_listo2) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("[TB] FAIL beat2_extra: pos=%0d indice=%0d with no beat expected", pos2, indice2);
            end else begin
                e = q2.pop_front();
                if (pos2 !== e.pos || indice2 !== e.indice || desborde2 !== e.desb) begin
                    errors++;
                    $display("[TB] FAIL beat2: got pos=%0d indice=%0d desborde=%0b, need pos=%0d indice=%0d desborde=%0b",
                             pos2, indice2, desborde2, e.pos, e.indice, e.desb);
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({ocupado, pos_valido, fin, desborde} !== 4'b0000 || pos !== '0 || indice !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: ocupado=%0b valido=%0b fin=%0b desb=%0b pos=%0d indice=%0d, need all 0",
                     ocupado, pos_valido, fin, desborde, pos, indice);
        end
        checks++;
        if ({ocupado2, pos_valido2, fin2, desborde2} !== 4'b0000 || pos2 !== '0 || indice2 !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state2: ocupado=%0b valido=%0b fin=%0b desb=%0b pos=%0d indice=%0d, need all 0",
                     ocupado2, pos_valido2, fin2, desborde2, pos2, indice2);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_basico();
        int ciclos;
        bit ok;
        @(posedge clk);
        #1;
        Posicion = 10'd100;
        inicio   = 1'b1;
        encolar(1, 100, 12, 1);
        @(negedge clk);
        checks++;
        if (pos_valido !== 1'b0 || ocupado !== 1'b0) begin
            errors++;
            $display("[TB] FAIL latencia_previa: valido=%0b ocupado=%0b, need 0 0", pos_valido, ocupado);
        end
        @(posedge clk);
        #1 inicio = 1'b0;
        @(negedge clk);
        checks++;
        if (pos_valido !== 1'b1 || ocupado !== 1'b1) begin
            errors++;
            $display("[TB] FAIL latencia: valido=%0b ocupado=%0b, need 1 1", pos_valido, ocupado);
        end
        esperar_vacio(1, 40, ciclos, ok);
        checks++;
        if (!ok || ciclos != 12) begin
            errors++;
            $display("[TB] FAIL rendimiento: drained=%0b after %0d cycles, need 1 after 12", ok, ciclos);
        end
        // Request a start during FIN; it must be ignored.
        #1 inicio = 1'b1;
        @(negedge clk);
        checks++;
        if (fin !== 1'b1 || ocupado !== 1'b1 || pos_valido !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fin_pulso: fin=%0b ocupado=%0b valido=%0b, need 1 1 0", fin, ocupado, pos_valido);
        end
        @(posedge clk);
        #1 inicio = 1'b0;
        @(negedge clk);
        checks++;
        if (fin !== 1'b0 || ocupado !== 1'b0 || pos_valido !== 1'b0) begin
            errors++;
            $display("[TB] FAIL inicio_en_fin: fin=%0b ocupado=%0b valido=%0b, need 0 0 0", fin, ocupado, pos_valido);
        end
    endtask

    task automatic test_desborde();
        int ciclos;
        bit ok;
        @(posedge clk);
        #1;
        Posicion = 10'd1020;
        inicio   = 1'b1;
        encolar(1, 1020, 12, 1);
        @(posedge clk);
        #1 inicio = 1'b0;
        esperar_vacio(1, 40, ciclos, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL desborde_timeout: %0d beats still pending", q1.size());
        end
        @(negedge clk);
        checks++;
        if (fin !== 1'b1 || desborde !== 1'b1) begin
            errors++;
            $display("[TB] FAIL desborde_sticky: fin=%0b desborde=%0b, need 1 1", fin, desborde);
        end
    endtask

    task automatic test_espera();
        int ciclos;
        bit ok;
        bit hallado;
        @(posedge clk);
        #1;
        Posicion = 10'd200;
        inicio   = 1'b1;
        encolar(1, 200, 12, 1);
        @(posedge clk);
        #1 inicio = 1'b0;
        hallado = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (pos_valido === 1'b1 && indice === 8'd5) begin
                hallado = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!hallado) begin
            errors++;
            $display("[TB] FAIL espera_indice5: indice=%0d, need 5 within 20 cycles", indice);
        end
        pos_listo = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (pos !== 10'd205 || indice !== 8'd5 || pos_valido !== 1'b1) begin
                errors++;
                $display("[TB] FAIL espera_estable: pos=%0d indice=%0d valido=%0b, need 205 5 1", pos, indice, pos_valido);
            end
        end
        @(posedge clk);
        #1 pos_listo = 1'b1;
        esperar_vacio(1, 40, ciclos, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL espera_timeout: %0d beats still pending", q1.size());
        end
        @(negedge clk);
        checks++;
        if (fin !== 1'b1) begin
            errors++;
            $display("[TB] FAIL espera_fin: fin=%0b, need 1", fin);
        end
    endtask

    task automatic test_paso4();
        int ciclos;
        bit ok;
        @(posedge clk);
        #1;
        Posicion2 = 10'd8;
        inicio2   = 1'b1;
        encolar(2, 8, 3, 4);
        @(posedge clk);
        #1 inicio2 = 1'b0;
        @(posedge clk);
        #1;
        Posicion2 = 10'd500;
        inicio2   = 1'b1;
        @(posedge clk);
        #1 inicio2 = 1'b0;
        esperar_vacio(2, 20, ciclos, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL paso4_timeout: %0d beats still pending", q2.size());
        end
        @(negedge clk);
        checks++;
        if (fin2 !== 1'b1 || pos_valido2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL paso4_fin: fin=%0b valido=%0b, need 1 0", fin2, pos_valido2);
        end
        @(negedge clk);
        checks++;
        if (ocupado2 !== 1'b0 || pos_valido2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL paso4_reinicio: ocupado=%0b valido=%0b, need 0 0", ocupado2, pos_valido2);
        end
    endtask

    task automatic test_reset_medio();
        int ciclos;
        bit ok;
        bit hallado;
        @(posedge clk);
        #1;
        Posicion = 10'd300;
        inicio   = 1'b1;
        encolar(1, 300, 12, 1);
        @(posedge clk);
        #1 inicio = 1'b0;
        hallado = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (indice === 8'd7) begin
                hallado = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!hallado) begin
            errors++;
            $display("[TB] FAIL reset_medio_indice7: indice=%0d, need 7 within 20 cycles", indice);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({ocupado, pos_valido, fin, desborde} !== 4'b0000 || pos !== '0 || indice !== '0) begin
            errors++;
            $display("[TB] FAIL reset_inmediato: ocupado=%0b valido=%0b fin=%0b desb=%0b pos=%0d indice=%0d, need all 0",
                     ocupado, pos_valido, fin, desborde, pos, indice);
        end
        q1.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        Posicion = 10'd0;
        inicio   = 1'b1;
        encolar(1, 0, 12, 1);
        @(posedge clk);
        #1 inicio = 1'b0;
        esperar_vacio(1, 40, ciclos, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL reset_nuevo_timeout: %0d beats still pending", q1.size());
        end
        @(negedge clk);
        checks++;
        if (fin !== 1'b1 || desborde !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_nuevo_fin: fin=%0b desborde=%0b, need 1 0", fin, desborde);
        end
    endtask

    initial begin
        test_reset();
        test_basico();
        test_desborde();
        test_espera();
        test_paso4();
        test_reset_medio();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, need completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
